// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator ALU command sequencer.
package alu_pkg;

    localparam int unsigned ALU_W = 8;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL = 3'b010;
    localparam logic [OP_W-1:0] OP_SHR = 3'b011;
    localparam logic [OP_W-1:0] OP_AND = 3'b100;
    localparam logic [OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR = 3'b110;
    localparam logic [OP_W-1:0] OP_NOT = 3'b111;

    // Idle drive: ADD 0 leaves the accumulator unchanged, since the ALU has no enable
    localparam logic             HOLD_RST    = 1'b0;
    localparam logic [OP_W-1:0]  HOLD_OPCODE = OP_ADD;
    localparam logic [ALU_W-1:0] HOLD_INT    = '0;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StExec,
        StCapt
    } state_e;

    typedef struct packed {
        logic             start;
        logic [ALU_W-1:0] int1;
        logic [ALU_W-1:0] int2;
        logic [OP_W-1:0]  opcode;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Count-based synchronous FIFO holding queued ALU commands; no empty bypass.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 8-bit accumulator ALU: queues commands, inserts the clear
// cycle that starts a chain, and returns tagged results on a backpressured stream.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_start,
    input  logic [ALU_W-1:0] cmd_int1,
    input  logic [ALU_W-1:0] cmd_int2,
    input  logic [OP_W-1:0]  cmd_opcode,
    output logic             alu_rst,
    output logic [ALU_W-1:0] alu_int1,
    output logic [ALU_W-1:0] alu_int2,
    output logic [OP_W-1:0]  alu_opcode,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_status,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ALU_W-1:0] res_data,
    output logic             res_carry,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    state_e           state_q, state_d;
    cmd_t             push_cmd, head_cmd;
    logic             fifo_full, fifo_empty, push, pop;
    logic [ALU_W-1:0] cur_int1_q, cur_int2_q;
    logic [OP_W-1:0]  cur_op_q;
    logic             chain_open_q;
    logic             rst_hold_q;
    logic             res_valid_q, res_carry_q;
    logic [ALU_W-1:0] res_data_q;
    logic [TAG_W-1:0] res_tag_q, tag_cnt_q;

    assign push_cmd  = '{start: cmd_start, int1: cmd_int1, int2: cmd_int2, opcode: cmd_opcode};
    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & ~fifo_full;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state, FIFO pop, and ALU drive decoded from state/cur registers only
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        alu_rst    = HOLD_RST;
        alu_int1   = HOLD_INT;
        alu_int2   = HOLD_INT;
        alu_opcode = HOLD_OPCODE;
        unique case (state_q)
            StIdle: begin
                // Only pop when the result slot will be free by CAPT
                if (!fifo_empty && (!res_valid_q || res_ready)) begin
                    pop     = 1'b1;
                    state_d = (head_cmd.start || !chain_open_q) ? StClear : StExec;
                end
            end
            StClear: begin
                alu_rst = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                alu_int1   = cur_int1_q;
                alu_int2   = cur_int2_q;
                alu_opcode = cur_op_q;
                state_d    = StCapt;
            end
            StCapt: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Keep the ALU cleared while reset is (or was just) applied
        if (rst_hold_q) alu_rst = 1'b1;
    end

    // State, current command and chain tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_int1_q   <= '0;
            cur_int2_q   <= '0;
            cur_op_q     <= OP_ADD;
            chain_open_q <= 1'b0;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= 1'b0;
            if (pop) begin
                cur_int1_q <= head_cmd.int1;
                cur_int2_q <= head_cmd.int2;
                cur_op_q   <= head_cmd.opcode;
            end
            if (state_q == StExec) chain_open_q <= 1'b1;
        end
    end

    // Result holding register and sequence tag counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_tag_q   <= '0;
            tag_cnt_q   <= '0;
        end else if (state_q == StCapt) begin
            res_valid_q <= 1'b1;
            res_data_q  <= alu_out;
            res_carry_q <= alu_status;
            res_tag_q   <= tag_cnt_q;
            tag_cnt_q   <= tag_cnt_q + TAG_W'(1);
        end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_tag   = res_tag_q;
    assign busy      = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural accumulator ALU.
module tb_alu_cmd_sequencer;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] XOR = 3'b110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_start;
    logic [7:0] cmd_int1, cmd_int2;
    logic [2:0] cmd_opcode;
    logic       alu_rst;
    logic [7:0] alu_int1, alu_int2;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       alu_status;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic [3:0] res_tag;
    logic       busy;

    int         passed = 0;
    int         total  = 0;
    logic [3:0] exp_tag;
    logic       watch = 1'b0;
    int         rst_seen = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .TAG_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_int1   (cmd_int1),
        .cmd_int2   (cmd_int2),
        .cmd_opcode (cmd_opcode),
        .alu_rst    (alu_rst),
        .alu_int1   (alu_int1),
        .alu_int2   (alu_int2),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_status (alu_status),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_tag    (res_tag),
        .busy       (busy)
    );

    // Behavioural accumulator ALU: seeds from int1 on the first cycle after rst
    logic [7:0] alu_acc;
    logic       alu_st, alu_seed;
    logic [8:0] alu_nxt;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {(a < b), a - b};
            3'b010:  return {a[7], a << 1};
            3'b011:  return {a[0], a >> 1};
            3'b100:  return {1'b0, a & b};
            3'b101:  return {1'b0, a | b};
            3'b110:  return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    assign alu_nxt    = alu_f(alu_seed ? alu_int1 : alu_acc, alu_int2, alu_opcode);
    assign alu_out    = alu_acc;
    assign alu_status = alu_st;

    always @(posedge clk) begin
        if (alu_rst) begin
            alu_acc  <= 8'd0;
            alu_st   <= 1'b0;
            alu_seed <= 1'b1;
        end else begin
            {alu_st, alu_acc} <= alu_nxt;
            alu_seed          <= 1'b0;
        end
    end

    // Count cycles with the ALU clear asserted while a window is open
    always @(negedge clk) begin
        if (!watch)       rst_seen <= 0;
        else if (alu_rst) rst_seen <= rst_seen + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else             passed++;
    endtask

    task automatic send(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op);
        int n;
        cmd_start  = s;
        cmd_int1   = a;
        cmd_int2   = b;
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        if (cmd_ready) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input logic [7:0] d, input logic c);
        int n;
        res_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_valid"}, res_valid, 1);
        if (res_valid) begin
            check({name, "_data"}, res_data, d);
            check({name, "_carry"}, res_carry, c);
            check({name, "_tag"}, res_tag, exp_tag);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b0;
        exp_tag   = exp_tag + 4'd1;
    endtask

    task automatic wait_latency(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    typedef struct {
        logic       start;
        logic [7:0] i1;
        logic [7:0] i2;
        logic [2:0] op;
        logic [7:0] d;
        logic       c;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 8'd10,  8'd1,  ADD, 8'd11,  1'b0};
        vecs[1] = '{1'b0, 8'd0,   8'd1,  ADD, 8'd12,  1'b0};
        vecs[2] = '{1'b0, 8'd0,   8'd1,  ADD, 8'd13,  1'b0};
        vecs[3] = '{1'b0, 8'd0,   8'd1,  ADD, 8'd14,  1'b0};
        vecs[4] = '{1'b1, 8'd20,  8'd5,  SUB, 8'd15,  1'b0};
        vecs[5] = '{1'b0, 8'd0,   8'd5,  SUB, 8'd10,  1'b0};
        vecs[6] = '{1'b1, 8'd220, 8'd10, ADD, 8'd230, 1'b0};
        vecs[7] = '{1'b0, 8'd0,   8'd10, ADD, 8'd240, 1'b0};
        vecs[8] = '{1'b0, 8'd0,   8'd10, ADD, 8'd250, 1'b0};
        vecs[9] = '{1'b0, 8'd0,   8'd10, ADD, 8'd4,   1'b1};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_start  = 1'b0;
        cmd_int1   = 8'd0;
        cmd_int2   = 8'd0;
        cmd_opcode = ADD;
        res_ready  = 1'b0;
        exp_tag    = 4'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_carry", res_carry, 0);
        check("rst_res_tag", res_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_rst", alu_rst, 1);
        check("rst_alu_ops", {alu_int1, alu_int2, 5'b0, alu_opcode}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_hold", {alu_rst, alu_int1, alu_int2, alu_opcode}, 0);

        // Chains: ADD, SUB, ADD with wrap into carry
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].start, vecs[i].i1, vecs[i].i2, vecs[i].op);
            get_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].c);
        end

        // First command after reset with start=0 still clears; CLEAR-path latency 4
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_tag = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        watch = 1'b1;
        send(1'b0, 8'd7, 8'd3, XOR);
        wait_latency("lat_clear", 4);
        check("forced_clear_pulse", rst_seen, 1);
        watch = 1'b0;
        get_result("xor_seed", 8'd4, 1'b0);
        // Chain continue: no clear, latency 3
        watch = 1'b1;
        send(1'b0, 8'd99, 8'd1, ADD);
        wait_latency("lat_chain", 3);
        check("chain_no_clear", rst_seen, 0);
        watch = 1'b0;
        get_result("chain_add", 8'd5, 1'b0);

        // Backpressure: five accepted, sixth stalls until results drain
        send(1'b1, 8'd1, 8'd1, ADD);
        for (int i = 0; i < 4; i++) send(1'b0, 8'd0, 8'd1, ADD);
        fork
            send(1'b0, 8'd0, 8'd1, ADD);
            begin
                repeat (2) @(posedge clk);
                #1;
                check("bp_cmd_ready", cmd_ready, 0);
                check("bp_busy", busy, 1);
                check("bp_res_held", res_valid, 1);
                for (int i = 0; i < 6; i++) get_result($sformatf("bp%0d", i), 8'(2 + i), 1'b0);
            end
        join
        check("bp_drained_busy", busy, 0);

        // Reset during EXEC discards the running and the queued command
        send(1'b1, 8'd50, 8'd9, SUB);
        send(1'b0, 8'd0, 8'd1, ADD);
        @(posedge clk);
        #1;
        check("exec_drive", {alu_rst, alu_int1, alu_int2, alu_opcode}, {1'b0, 8'd50, 8'd9, SUB});
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_alu_rst", alu_rst, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_tag = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", busy, 0);
        watch = 1'b1;
        send(1'b0, 8'd6, 8'd2, ADD);
        wait_latency("post_rst_lat", 4);
        check("post_rst_clear", rst_seen, 1);
        watch = 1'b0;
        get_result("post_rst", 8'd8, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
